bitstream_packer: RTL and testbench
===================================

BITSTREAM_PACKER -- requirements
Module: bitstream_packer

Interface
REQ-001 Parameter ACC_WIDTH, default 64: bit-accumulator depth, minimum 40.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low: asserting low resets immediately, release is synchronous to clk.
REQ-004 sym_valid  input  1  a symbol is presented on code/code_len/vli/vli_len.
REQ-005 sym_ready  output  1  the packer can accept a symbol this cycle.
REQ-006 code  input  16  Huffman code, right-justified.
REQ-007 code_len  input  5  number of valid code bits, 0..16.
REQ-008 vli  input  11  VLI amplitude bits, right-justified.
REQ-009 vli_len  input  4  number of valid VLI bits, 0..11.
REQ-010 flush  input  1  end-of-scan request, sampled only when flush and sym_ready are both high.
REQ-011 flush_done  output  1  one-cycle pulse when a flush has fully drained.
REQ-012 byte_out  output  8  output byte of the JPEG entropy-coded stream.
REQ-013 byte_valid  output  1  byte_out holds a valid byte.
REQ-014 byte_ready  input  1  downstream accepts byte_out this cycle.
REQ-015 bit_count  output  clog2(ACC_WIDTH+1)  current accumulator occupancy in bits.

Function
REQ-016 A symbol transfer occurs on sym_valid && sym_ready.
- The low code_len bits of code are appended MSB-first to the accumulator tail.
- The low vli_len bits of vli are then appended MSB-first.
- bit_count increases by code_len+vli_len.
REQ-017 sym_ready SHALL be high only when all of these hold:
- the FSM is in RUN;
- bit_count <= ACC_WIDTH-27;
- bit_count reflects only registered state (no combinational path from sym_valid).
REQ-018 A symbol with code_len=0 and vli_len=0 is accepted and leaves the state unchanged.
REQ-019 code_len>16 or vli_len>11 is illegal; behaviour is unspecified and the bench flags it with an assertion.
REQ-020 Output register behaviour:
- The output register loads when it is empty, or when byte_valid && byte_ready in the same cycle.
- It never loads more than one byte per cycle.
- byte_out and byte_valid SHALL hold stable while byte_valid && !byte_ready.
REQ-021 In RUN with bit_count>=8, the load takes the 8 oldest bits, with the oldest bit at byte_out[7], and bit_count decreases by 8.
REQ-022 Byte stuffing: when a byte equal to 0xFF is loaded, the FSM enters STUFF, and the next load is 0x00 before any accumulator byte.
- Append and extract SHALL work in the same cycle.
- Net count = bit_count + appended - (8 if extracted).
REQ-023 FSM states and transitions:
- RUN: normal operation.
- STUFF: loads 0x00, then returns to the state it came from.
- DRAIN: flush accepted; no symbols accepted; emit whole bytes until bit_count<8.
- PAD: if 0<bit_count<8, load the remaining bits left-aligned with the low bits filled with 1s; bit_count becomes 0; a padded 0xFF is also stuffed.
- DONE: wait until the output register is empty and consumed, pulse flush_done for one cycle, then go to RUN.
REQ-024 A symbol and flush accepted in the same cycle: the symbol is appended first, then the flush applies to it.
REQ-025 A flush with bit_count=0 emits no pad byte; flush_done follows once the output register is empty.
REQ-026 sym_ready SHALL be low in STUFF, DRAIN, PAD and DONE.

Reset
REQ-027 While rst is low, all of the following hold:
- accumulator cleared, bit_count=0;
- FSM=RUN;
- byte_out=0x00, byte_valid=0;
- flush_done=0;
- sym_ready=0.
REQ-028 The first cycle after release has sym_ready=1; reset mid-operation discards all pending bits and bytes without emitting them.

Verification
REQ-029 code=0b00 (len 2), vli=0b101 (len 3), then flush -> single byte 0x2F, then a flush_done pulse.
REQ-030 code=0xFF (len 8), vli_len=0, then flush -> bytes 0xFF, 0x00, then flush_done, with no pad byte.
REQ-031 code=0x1234 (len 16) with flush in the same cycle -> bytes 0x12, 0x34, then flush_done.
REQ-032 byte_ready held low, 16-bit symbols streamed:
- sym_ready drops once bit_count > ACC_WIDTH-27;
- byte_out is stable while stalled;
- releasing byte_ready drains in order with no loss or duplication.
REQ-033 code=0b111 (len 3), then flush -> pad gives 0xFF, so bytes 0xFF, 0x00, then flush_done.
REQ-034 rst asserted low with bit_count=20 and byte_valid=1 -> outputs go to reset values immediately; after release no stale byte appears.

Source files
------------

// File: rtl/bitstream_packer.sv
// JPEG entropy-coded bitstream packer.
// Appends Huffman code + VLI bits into a bit accumulator and emits bytes
// MSB-first. Any emitted 0xFF is followed by a stuffed 0x00. A flush drains
// whole bytes, then pads the remaining bits with 1s, then pulses flush_done.
module bitstream_packer #(
  parameter int ACC_WIDTH = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           sym_valid,
  output logic                           sym_ready,
  input  logic [15:0]                    code,
  input  logic [4:0]                     code_len,
  input  logic [10:0]                    vli,
  input  logic [3:0]                     vli_len,
  input  logic                           flush,
  output logic                           flush_done,
  output logic [7:0]                     byte_out,
  output logic                           byte_valid,
  input  logic                           byte_ready,
  output logic [$clog2(ACC_WIDTH+1)-1:0] bit_count
);

  localparam int CW = $clog2(ACC_WIDTH + 1);
  // Largest occupancy that still has room for a worst-case 27-bit symbol.
  localparam logic [CW-1:0] READY_LIMIT = CW'(ACC_WIDTH - 27);
  localparam logic [CW-1:0] EIGHT       = CW'(8);

  typedef enum logic [2:0] {RUN, STUFF, DRAIN, PAD, DONE} state_t;

  // Bits are kept right-justified: the oldest valid bit sits at
  // position count_reg-1, new bits shift in at bit 0.
  logic [ACC_WIDTH-1:0] acc_reg, acc_next, acc_app;
  logic [CW-1:0]        count_reg, count_next, count_app;
  state_t               state_reg, state_next;
  state_t               ret_reg, ret_next;
  logic [7:0]           out_reg, out_next;
  logic                 valid_reg, valid_next;
  logic                 done_reg, done_next;
  logic                 ready_reg, ready_next;

  logic                 accept, flush_take, can_load, have_byte;
  logic [15:0]          code_mask;
  logic [10:0]          vli_mask;
  logic [26:0]          sym_bits;
  logic [5:0]           sym_len;
  logic [7:0]           head_byte, pad_byte;
  logic [2:0]           tail_bits;

  assign sym_ready  = ready_reg;
  assign flush_done = done_reg;
  assign byte_out   = out_reg;
  assign byte_valid = valid_reg;
  assign bit_count  = count_reg;

  // ready_reg is only ever set when the FSM is heading into RUN.
  assign accept     = sym_valid && ready_reg;
  assign flush_take = flush && ready_reg;
  // Output register may load when empty or when its byte leaves this cycle.
  assign can_load   = !valid_reg || byte_ready;
  assign have_byte  = count_reg >= EIGHT;

  // Mask lengths of 16/11 wrap to all-ones naturally in the narrow arithmetic.
  assign code_mask = (16'd1 << code_len) - 16'd1;
  assign vli_mask  = (11'd1 << vli_len) - 11'd1;
  assign sym_bits  = ({11'd0, code & code_mask} << vli_len) | {16'd0, vli & vli_mask};
  assign sym_len   = {1'b0, code_len} + {2'b00, vli_len};

  assign acc_app   = accept ? ((acc_reg << sym_len) | {{(ACC_WIDTH-27){1'b0}}, sym_bits})
                            : acc_reg;
  assign count_app = count_reg + (accept ? CW'(sym_len) : '0);

  // Oldest 8 bits (valid only when have_byte) and the left-aligned pad byte.
  assign head_byte = 8'(acc_reg >> (count_reg - EIGHT));
  assign tail_bits = count_reg[2:0];
  assign pad_byte  = (acc_reg[7:0] << (4'd8 - {1'b0, tail_bits})) | (8'hFF >> tail_bits);

  // Next-state and datapath selection for the packer FSM.
  always_comb begin
    acc_next   = acc_app;
    count_next = count_app;
    state_next = state_reg;
    ret_next   = ret_reg;
    out_next   = out_reg;
    valid_next = valid_reg && !byte_ready;
    done_next  = 1'b0;
    case (state_reg)
      RUN: begin
        if (can_load && have_byte) begin
          out_next   = head_byte;
          valid_next = 1'b1;
          count_next = count_app - EIGHT;
        end
        if (can_load && have_byte && head_byte == 8'hFF) begin
          state_next = STUFF;
          ret_next   = flush_take ? DRAIN : RUN;
        end else if (flush_take) begin
          state_next = DRAIN;
        end
      end
      STUFF: begin
        if (can_load) begin
          out_next   = 8'h00;
          valid_next = 1'b1;
          state_next = ret_reg;
        end
      end
      DRAIN: begin
        if (have_byte) begin
          if (can_load) begin
            out_next   = head_byte;
            valid_next = 1'b1;
            count_next = count_reg - EIGHT;
            if (head_byte == 8'hFF) begin
              state_next = STUFF;
              ret_next   = DRAIN;
            end
          end
        end else if (count_reg != '0) begin
          state_next = PAD;
        end else begin
          state_next = DONE;
        end
      end
      PAD: begin
        if (can_load) begin
          out_next   = pad_byte;
          valid_next = 1'b1;
          count_next = '0;
          ret_next   = DONE;
          state_next = (pad_byte == 8'hFF) ? STUFF : DONE;
        end
      end
      DONE: begin
        if (!valid_reg) begin
          done_next  = 1'b1;
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
    ready_next = (state_next == RUN) && (count_next <= READY_LIMIT);
  end

  // State and registered outputs; reset discards all pending bits and bytes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg   <= '0;
      count_reg <= '0;
      state_reg <= RUN;
      ret_reg   <= RUN;
      out_reg   <= 8'h00;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      acc_reg   <= acc_next;
      count_reg <= count_next;
      state_reg <= state_next;
      ret_reg   <= ret_next;
      out_reg   <= out_next;
      valid_reg <= valid_next;
      done_reg  <= done_next;
      ready_reg <= ready_next;
    end
  end

endmodule

// File: tb/tb_bitstream_packer.sv
// Testbench for bitstream_packer: directed cases plus randomized traffic
// checked against a bit-queue reference model of the JPEG byte stream.
module tb_bitstream_packer;
  localparam int AW = 64;
  localparam int CW = $clog2(AW + 1);

  logic          clk, rst;
  logic          sym_valid, sym_ready, flush, flush_done;
  logic          byte_valid, byte_ready;
  logic [15:0]   code;
  logic [4:0]    code_len;
  logic [10:0]   vli;
  logic [3:0]    vli_len;
  logic [7:0]    byte_out;
  logic [CW-1:0] bit_count;

  int total = 0;
  int bad   = 0;

  bit         bq[$];     // reference: bits accepted but not yet formed into bytes
  logic [7:0] expq[$];   // reference: expected output byte stream
  logic [7:0] got[$];    // bytes actually transferred downstream

  bitstream_packer #(.ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .sym_valid(sym_valid), .sym_ready(sym_ready),
    .code(code), .code_len(code_len), .vli(vli), .vli_len(vli_len),
    .flush(flush), .flush_done(flush_done),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .bit_count(bit_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: stream of bits, cut into bytes, 0xFF followed by 0x00.
  task automatic m_push(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bq.push_back(v[i]);
  endtask

  task automatic m_emit(input logic [7:0] b);
    expq.push_back(b);
    if (b == 8'hFF) expq.push_back(8'h00);
  endtask

  task automatic m_drain();
    logic [7:0] b;
    while (bq.size() >= 8) begin
      for (int i = 0; i < 8; i++) b[7-i] = bq.pop_front();
      m_emit(b);
    end
  endtask

  task automatic m_flush();
    logic [7:0] b;
    m_drain();
    if (bq.size() > 0) begin
      b = 8'hFF;
      for (int i = 0; i < bq.size(); i++) b[7-i] = bq[i];
      bq.delete();
      m_emit(b);
    end
  endtask

  // Monitor: follows transfers on the falling edge, checks bytes and handshake rules.
  initial begin
    logic       stall_prev;
    logic [7:0] prev_byte;
    stall_prev = 1'b0;
    prev_byte  = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stall_prev = 1'b0;
        continue;
      end
      if (sym_valid) begin
        total++;
        assert (code_len <= 16 && vli_len <= 11) else begin
          bad++;
          $error("FAIL illegal_len: code_len=%0d vli_len=%0d", code_len, vli_len);
        end
      end
      if (sym_valid && sym_ready) begin
        m_push(code, int'(code_len));
        m_push({5'd0, vli}, int'(vli_len));
        m_drain();
      end
      if (flush && sym_ready) m_flush();
      total++;
      assert (!sym_ready || bit_count <= CW'(AW - 27)) else begin
        bad++;
        $error("FAIL ready_limit: bit_count=%0d required<=%0d", bit_count, AW - 27);
      end
      if (stall_prev) begin
        total++;
        assert (byte_valid === 1'b1 && byte_out === prev_byte) else begin
          bad++;
          $error("FAIL stall_hold: observed=%0h/%0b expected=%0h/1", byte_out, byte_valid, prev_byte);
        end
      end
      stall_prev = byte_valid && !byte_ready;
      prev_byte  = byte_out;
      if (byte_valid && byte_ready) begin
        got.push_back(byte_out);
        total++;
        if (expq.size() == 0) begin
          bad++;
          $error("FAIL byte_unexpected: observed=%0h expected=none", byte_out);
        end else begin
          assert (byte_out === expq[0]) else begin
            bad++;
            $error("FAIL byte_stream: observed=%0h expected=%0h", byte_out, expq[0]);
          end
          void'(expq.pop_front());
        end
      end
    end
  end

  // One handshake with the packer: symbol and/or flush, bounded wait for sym_ready.
  task automatic xfer(input logic sv, input logic [15:0] c, input logic [4:0] cl,
                      input logic [10:0] v, input logic [3:0] vl, input logic f);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    @(posedge clk); #1;
    sym_valid = sv; code = c; code_len = cl; vli = v; vli_len = vl; flush = f;
    while (n < 500 && !ok) begin
      @(negedge clk);
      if (sym_ready) ok = 1'b1;
      else n++;
    end
    @(posedge clk); #1;
    sym_valid = 1'b0;
    flush     = 1'b0;
    chk("xfer_ready", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (n < 3000 && !seen) begin
      @(negedge clk);
      if (flush_done) seen = 1'b1;
      n++;
    end
    chk({tag, "_done"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      @(negedge clk);
      chk({tag, "_pulse"}, {31'd0, flush_done}, 32'd0);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_ready"}, {31'd0, sym_ready}, 32'd0);
    chk({tag, "_count"}, {25'd0, bit_count}, 32'd0);
    chk({tag, "_valid"}, {31'd0, byte_valid}, 32'd0);
    chk({tag, "_byte"},  {24'd0, byte_out}, 32'd0);
    chk({tag, "_fdone"}, {31'd0, flush_done}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; sym_valid = 1'b0; flush = 1'b0; byte_ready = 1'b1;
    code = '0; code_len = '0; vli = '0; vli_len = '0;

    // Reset state, then first cycle after release is ready
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("release_ready", {31'd0, sym_ready}, 32'd1);

    // 00 + 101 padded -> 0x2F
    got.delete();
    xfer(1, 16'h0000, 5'd2, 11'h005, 4'd3, 0);
    xfer(0, 16'h0000, 5'd0, 11'h000, 4'd0, 1);
    wait_done("t2f");
    chk("t2f_size", got.size(), 1);
    chk("t2f_byte", {24'd0, got[0]}, 32'h2F);

    // Zero-length symbol leaves state unchanged
    got.delete();
    xfer(1, 16'h0005, 5'd3, 11'h000, 4'd0, 0);
    idle(3);
    chk("zero_pre", {25'd0, bit_count}, 32'd3);
    xfer(1, 16'hFFFF, 5'd0, 11'h7FF, 4'd0, 0);
    idle(2);
    chk("zero_post", {25'd0, bit_count}, 32'd3);
    xfer(0, 16'h0000, 5'd0, 11'h000, 4'd0, 1);
    wait_done("zero");
    chk("zero_byte", {24'd0, got[0]}, 32'hBF);

    // 0xFF is stuffed, no pad byte
    got.delete();
    xfer(1, 16'h00FF, 5'd8, 11'h000, 4'd0, 0);
    xfer(0, 16'h0000, 5'd0, 11'h000, 4'd0, 1);
    wait_done("tff");
    chk("tff_size", got.size(), 2);
    chk("tff_b0", {24'd0, got[0]}, 32'hFF);
    chk("tff_b1", {24'd0, got[1]}, 32'h00);

    // Symbol and flush in the same cycle
    got.delete();
    xfer(1, 16'h1234, 5'd16, 11'h000, 4'd0, 1);
    wait_done("t1234");
    chk("t1234_size", got.size(), 2);
    chk("t1234_b0", {24'd0, got[0]}, 32'h12);
    chk("t1234_b1", {24'd0, got[1]}, 32'h34);

    // Padded byte of all 1s is stuffed too
    got.delete();
    xfer(1, 16'h0007, 5'd3, 11'h000, 4'd0, 0);
    xfer(0, 16'h0000, 5'd0, 11'h000, 4'd0, 1);
    wait_done("tpad");
    chk("tpad_size", got.size(), 2);
    chk("tpad_b0", {24'd0, got[0]}, 32'hFF);
    chk("tpad_b1", {24'd0, got[1]}, 32'h00);

    // Flush with empty accumulator emits nothing
    got.delete();
    xfer(0, 16'h0000, 5'd0, 11'h000, 4'd0, 1);
    wait_done("tempty");
    chk("tempty_size", got.size(), 0);

    // Back-pressure: stream 16-bit symbols with byte_ready low
    got.delete();
    byte_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      sym_valid = 1'b1; code = 16'($urandom); code_len = 5'd16;
      vli = '0; vli_len = '0; flush = 1'b0;
    end
    @(negedge clk);
    chk("stall_ready", {31'd0, sym_ready}, 32'd0);
    chk("stall_full", {31'd0, (bit_count > CW'(AW - 27))}, 32'd1);
    chk("stall_valid", {31'd0, byte_valid}, 32'd1);
    @(posedge clk); #1;
    sym_valid = 1'b0;
    byte_ready = 1'b1;
    xfer(0, 16'h0000, 5'd0, 11'h000, 4'd0, 1);
    wait_done("stall");
    chk("stall_left", expq.size(), 0);
    chk("stall_count", {31'd0, (got.size() >= 5)}, 32'd1);

    // Randomized traffic with random back-pressure and occasional flushes
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #1;
      sym_valid  = ($urandom % 4) != 0;
      code       = (($urandom % 3) == 0) ? 16'hFFFF : 16'($urandom);
      code_len   = 5'($urandom_range(0, 16));
      vli        = 11'($urandom);
      vli_len    = 4'($urandom_range(0, 11));
      flush      = ($urandom % 50) == 0;
      byte_ready = ($urandom % 3) != 0;
    end
    @(posedge clk); #1;
    sym_valid = 1'b0; flush = 1'b0; byte_ready = 1'b1;
    xfer(0, 16'h0000, 5'd0, 11'h000, 4'd0, 1);
    wait_done("rand");
    chk("rand_left", expq.size(), 0);
    chk("rand_count", {25'd0, bit_count}, 32'd0);

    // Reset in the middle of a stalled stream
    got.delete();
    byte_ready = 1'b0;
    xfer(1, 16'($urandom), 5'd16, 11'h000, 4'd0, 0);
    xfer(1, 16'($urandom), 5'd12, 11'h000, 4'd0, 0);
    idle(2);
    chk("mid_valid", {31'd0, byte_valid}, 32'd1);
    chk("mid_count", {25'd0, bit_count}, 32'd20);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_reset_state("midrst");
    expq.delete();
    bq.delete();
    got.delete();
    byte_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_release", {31'd0, sym_ready}, 32'd1);
    idle(5);
    chk("midrst_stale", got.size(), 0);
    xfer(0, 16'h0000, 5'd0, 11'h000, 4'd0, 1);
    wait_done("midrst");
    chk("midrst_none", got.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
